k005297_stopreq_ctrl: RTL and testbench

Initiator side of the 2 MHz subclock start/stop handshake in the K005297 bubble memory controller. It accepts hold requests from two internal units, channel 0 (bus access wait) and channel 1 (page buffer full). For each request it drives an active-low stop request into the supervisor at a fixed ROT20 slot. It waits for the supervisor's stop and delayed-stop flags, acknowledges the requester while the subclock is frozen, and releases the request cleanly. An optional watchdog flags a stop request that the supervisor never honours.

---
 rtl/k005297_pkg.sv | 7 +
 rtl/k005297_stopreq_ch.sv | 81 ++++++++
 rtl/k005297_stopreq_ctrl.sv | 75 +++++++
 tb/tb_k005297_stopreq_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/k005297_pkg.sv
// k005297_pkg: shared types and constants for the K005297 subclock stop-request logic
// Contents: stopreq_state_t channel FSM states, ROT20_LEN rotator width, WDT_W watchdog width
package k005297_pkg;
    localparam int ROT20_LEN = 20;
    localparam int WDT_W     = 8;
    typedef enum logic [2:0] {IDLE, ARM, REQ, HOLD, REL} stopreq_state_t;
endpackage

// File: rtl/k005297_stopreq_ch.sv
// k005297_stopreq_ch: one channel of the 2 MHz subclock stop-request handshake
// Ports: i_MCLK/i_MRST_n clock and async active-low reset; i_CLK4M_PCEN_n 4 MHz enable (active-low);
//        i_ROT_SLOT_n rotator bit at the stop slot; i_SYS_RUN_FLAG supervisor run flag;
//        i_CLK2M_STOP_n/i_CLK2M_STOP_DLYD_n supervisor stop flags; i_REQ hold request;
//        i_SIB_STOPRQ_n sibling channel stop line; o_ACK freeze acknowledge;
//        o_CLK2M_STOPRQ_n stop request (active-low); o_WDT_PULSE watchdog timeout (one enable)
// Build option: K005297_STOPRQ_WDT_EN adds the REQ-state watchdog counter.
module k005297_stopreq_ch
    import k005297_pkg::*;
#(
    parameter logic [WDT_W-1:0] WDT_LIMIT = 8'd255
) (
    input  logic i_MCLK,
    input  logic i_MRST_n,
    input  logic i_CLK4M_PCEN_n,
    input  logic i_ROT_SLOT_n,
    input  logic i_SYS_RUN_FLAG,
    input  logic i_CLK2M_STOP_n,
    input  logic i_CLK2M_STOP_DLYD_n,
    input  logic i_REQ,
    input  logic i_SIB_STOPRQ_n,
    output logic o_ACK,
    output logic o_CLK2M_STOPRQ_n,
    output logic o_WDT_PULSE
);
    stopreq_state_t state, state_nx;
    logic wdt_hit;
    logic frozen;

    assign frozen = !(i_CLK2M_STOP_n | i_CLK2M_STOP_DLYD_n);

`ifdef K005297_STOPRQ_WDT_EN
    logic [WDT_W-1:0] wdt_cnt;

    // counts enables spent in REQ; zero on every entry into REQ
    always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
        if (!i_MRST_n)
            wdt_cnt <= '0;
        else if (!i_CLK4M_PCEN_n)
            wdt_cnt <= (state == REQ && state_nx == REQ) ? wdt_cnt + 1'b1 : '0;
    end

    assign wdt_hit = wdt_cnt == WDT_LIMIT - 1'b1;
`else
    logic unused_lim;
    assign unused_lim = ^WDT_LIMIT;
    assign wdt_hit    = 1'b0;
`endif

    always_comb begin
        state_nx    = state;
        o_WDT_PULSE = 1'b0;
        if (!i_SYS_RUN_FLAG)
            state_nx = IDLE;
        else
            case (state)
                IDLE: state_nx = i_REQ ? ARM : IDLE;
                ARM:  state_nx = !i_REQ ? IDLE : !i_ROT_SLOT_n ? REQ : ARM;
                REQ: begin
                    state_nx    = !i_REQ ? REL : frozen ? HOLD : wdt_hit ? REL : REQ;
                    o_WDT_PULSE = i_REQ & !frozen & wdt_hit;
                end
                HOLD: state_nx = i_REQ ? HOLD : REL;
                // a low sibling line means the sibling still owns the freeze
                REL:  state_nx = (i_CLK2M_STOP_DLYD_n || !i_SIB_STOPRQ_n) ? IDLE : REL;
                default: state_nx = IDLE;
            endcase
    end

    always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            state            <= IDLE;
            o_CLK2M_STOPRQ_n <= 1'b1;
            o_ACK            <= 1'b0;
        end else if (!i_CLK4M_PCEN_n) begin
            state            <= state_nx;
            o_CLK2M_STOPRQ_n <= !(state_nx == REQ || state_nx == HOLD);
            o_ACK            <= state_nx == HOLD;
        end
    end
endmodule

// File: rtl/k005297_stopreq_ctrl.sv
// k005297_stopreq_ctrl: two-channel initiator of the K005297 2 MHz subclock stop handshake
// Ports: i_MCLK/i_MRST_n clock and async active-low reset; i_CLK4M_PCEN_n 4 MHz enable (active-low);
//        i_ROT20_n one-hot active-low rotator; i_SYS_RUN_FLAG run flag;
//        i_CLK2M_STOP_n/i_CLK2M_STOP_DLYD_n supervisor stop flags; i_REQ[1:0] hold requests;
//        o_ACK[1:0] freeze acknowledges; o_CLK2M_STOPRQ0_n/o_CLK2M_STOPRQ1_n stop requests;
//        i_WDT_CLR clears o_WDT_ERR; o_WDT_ERR sticky watchdog error
// Build option: K005297_STOPRQ_WDT_EN enables the watchdog; otherwise o_WDT_ERR is tied low.
module k005297_stopreq_ctrl
    import k005297_pkg::*;
#(
    parameter int unsigned      STOP_SLOT = 19,
    parameter logic [WDT_W-1:0] WDT_LIMIT = 8'd255
) (
    input  logic                 i_MCLK,
    input  logic                 i_MRST_n,
    input  logic                 i_CLK4M_PCEN_n,
    input  logic [ROT20_LEN-1:0] i_ROT20_n,
    input  logic                 i_SYS_RUN_FLAG,
    input  logic                 i_CLK2M_STOP_n,
    input  logic                 i_CLK2M_STOP_DLYD_n,
    input  logic [1:0]           i_REQ,
    output logic [1:0]           o_ACK,
    output logic                 o_CLK2M_STOPRQ0_n,
    output logic                 o_CLK2M_STOPRQ1_n,
    input  logic                 i_WDT_CLR,
    output logic                 o_WDT_ERR
);
    logic [1:0] wdt_pulse;
    logic       unused_ok;

    k005297_stopreq_ch #(.WDT_LIMIT(WDT_LIMIT)) u_ch0 (
        .i_MCLK              (i_MCLK),
        .i_MRST_n            (i_MRST_n),
        .i_CLK4M_PCEN_n      (i_CLK4M_PCEN_n),
        .i_ROT_SLOT_n        (i_ROT20_n[STOP_SLOT]),
        .i_SYS_RUN_FLAG      (i_SYS_RUN_FLAG),
        .i_CLK2M_STOP_n      (i_CLK2M_STOP_n),
        .i_CLK2M_STOP_DLYD_n (i_CLK2M_STOP_DLYD_n),
        .i_REQ               (i_REQ[0]),
        .i_SIB_STOPRQ_n      (o_CLK2M_STOPRQ1_n),
        .o_ACK               (o_ACK[0]),
        .o_CLK2M_STOPRQ_n    (o_CLK2M_STOPRQ0_n),
        .o_WDT_PULSE         (wdt_pulse[0])
    );

    k005297_stopreq_ch #(.WDT_LIMIT(WDT_LIMIT)) u_ch1 (
        .i_MCLK              (i_MCLK),
        .i_MRST_n            (i_MRST_n),
        .i_CLK4M_PCEN_n      (i_CLK4M_PCEN_n),
        .i_ROT_SLOT_n        (i_ROT20_n[STOP_SLOT]),
        .i_SYS_RUN_FLAG      (i_SYS_RUN_FLAG),
        .i_CLK2M_STOP_n      (i_CLK2M_STOP_n),
        .i_CLK2M_STOP_DLYD_n (i_CLK2M_STOP_DLYD_n),
        .i_REQ               (i_REQ[1]),
        .i_SIB_STOPRQ_n      (o_CLK2M_STOPRQ0_n),
        .o_ACK               (o_ACK[1]),
        .o_CLK2M_STOPRQ_n    (o_CLK2M_STOPRQ1_n),
        .o_WDT_PULSE         (wdt_pulse[1])
    );

`ifdef K005297_STOPRQ_WDT_EN
    // a timeout on the same enable as a clear wins
    always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
        if (!i_MRST_n)
            o_WDT_ERR <= 1'b0;
        else if (!i_CLK4M_PCEN_n)
            o_WDT_ERR <= |wdt_pulse | (o_WDT_ERR & ~i_WDT_CLR);
    end

    assign unused_ok = &{1'b0, i_ROT20_n};
`else
    assign o_WDT_ERR = 1'b0;
    assign unused_ok = &{1'b0, i_ROT20_n, i_WDT_CLR, wdt_pulse};
`endif
endmodule

// File: tb/tb_k005297_stopreq_ctrl.sv
// tb_k005297_stopreq_ctrl: directed self-checking bench for k005297_stopreq_ctrl
module tb_k005297_stopreq_ctrl;
    logic        clk = 1'b0;
    logic        mrst_n = 1'b0;
    logic        pcen_n = 1'b1;
    logic [19:0] rot_n;
    logic        run = 1'b1;
    logic        stop_n = 1'b1;
    logic        dlyd_n = 1'b1;
    logic [1:0]  req = 2'b11;
    logic [1:0]  ack;
    logic        stop0, stop1;
    logic        clr = 1'b0;
    logic        err;

    int vecs = 0;
    int errs = 0;
    int slot = 19;
    logic sub = 1'b0;
    int smp;
    int n;
    logic seen;

    always #5 clk = ~clk;

    k005297_stopreq_ctrl #(.STOP_SLOT(19), .WDT_LIMIT(8'd4)) dut (
        .i_MCLK              (clk),
        .i_MRST_n            (mrst_n),
        .i_CLK4M_PCEN_n      (pcen_n),
        .i_ROT20_n           (rot_n),
        .i_SYS_RUN_FLAG      (run),
        .i_CLK2M_STOP_n      (stop_n),
        .i_CLK2M_STOP_DLYD_n (dlyd_n),
        .i_REQ               (req),
        .o_ACK               (ack),
        .o_CLK2M_STOPRQ0_n   (stop0),
        .o_CLK2M_STOPRQ1_n   (stop1),
        .i_WDT_CLR           (clr),
        .o_WDT_ERR           (err)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // one enabled edge, then the supervisor rotator steps (only while running), then one idle edge
    task automatic tick();
        smp = slot * 2 + int'(sub);
        pcen_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        pcen_n = 1'b1;
        if (stop_n) begin
            sub = ~sub;
            if (!sub) slot = (slot == 19) ? 0 : slot + 1;
        end
        rot_n = ~(20'd1 << slot);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic align(input int s);
        for (int i = 0; i < 60 && !(slot == s && sub == 1'b0); i++) tick();
        check("align", 8'(slot * 2 + int'(sub)), 8'(s * 2));
    endtask

    task automatic wait_fall(input int ch, input string tag, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while ((ch == 1 ? stop1 : stop0) && cnt < 100);
        check(tag, {7'd0, ch == 1 ? stop1 : stop0}, 8'd0);
    endtask

    initial begin
        rot_n = ~(20'd1 << slot);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("reset_outs", {3'd0, stop0, stop1, ack, err}, 8'b0001_1000);
        end
        req = 2'b00;
        slot = 0;
        sub = 1'b0;
        rot_n = ~20'd1;
        mrst_n = 1'b1;
        tick();
        check("post_reset", {3'd0, stop0, stop1, ack, err}, 8'b0001_1000);

        align(3);
        req = 2'b01;
        tick();
        check("arm_no_stop", {7'd0, stop0}, 8'd1);
        wait_fall(0, "ch0_fall", n);
        check("ch0_latency", 8'(n + 1), 8'd33);
        check("ch0_slot", 8'(smp), 8'd38);
        check("ch1_idle", {7'd0, stop1}, 8'd1);
        stop_n = 1'b0;
        tick();
        check("ack_one_flag", {6'd0, ack}, 8'b00);
        dlyd_n = 1'b0;
        tick();
        check("ack0_rise", {5'd0, stop0, ack}, 8'b001);
        req = 2'b00;
        @(posedge clk);
        @(negedge clk);
        check("no_enable_hold", {5'd0, stop0, ack}, 8'b001);
        tick();
        check("ch0_release", {5'd0, stop0, ack}, 8'b100);
        stop_n = 1'b1;
        dlyd_n = 1'b1;
        tick();

        align(10);
        req = 2'b11;
        wait_fall(0, "both_fall", n);
        check("both_together", {6'd0, stop0, stop1}, 8'b00);
        stop_n = 1'b0;
        dlyd_n = 1'b0;
        tick();
        check("both_ack", {6'd0, ack}, 8'b11);
        req = 2'b10;
        tick();
        check("ch0_rel", {4'd0, stop0, stop1, ack}, 8'b1010);
        tick();
        check("ch0_sib_idle", {4'd0, stop0, stop1, ack}, 8'b1010);
        req = 2'b00;
        tick();
        check("ch1_rel", {4'd0, stop0, stop1, ack}, 8'b1100);
        stop_n = 1'b1;
        dlyd_n = 1'b1;
        tick();

        req = 2'b10;
        wait_fall(1, "ch1_fall", n);
        stop_n = 1'b0;
        dlyd_n = 1'b0;
        tick();
        check("ch1_hold", {5'd0, stop1, ack}, 8'b010);
        run = 1'b0;
        tick();
        check("run_drop", {5'd0, stop1, ack}, 8'b100);
        stop_n = 1'b1;
        dlyd_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 45; i++) begin
            tick();
            seen = seen | !stop1;
        end
        check("run_low_ignored", {7'd0, seen}, 8'd0);
        run = 1'b1;
        wait_fall(1, "ch1_rearm", n);
        req = 2'b00;
        tick();
        check("ch1_drop", {5'd0, stop1, ack}, 8'b100);
        tick();

        req = 2'b01;
        wait_fall(0, "wdt_req", n);
`ifdef K005297_STOPRQ_WDT_EN
        for (int i = 0; i < 3; i++) tick();
        check("wdt_before", {6'd0, stop0, err}, 8'b00);
        clr = 1'b1;
        tick();
        check("wdt_fire", {6'd0, stop0, err}, 8'b11);
        req = 2'b00;
        tick();
        check("wdt_clear", {6'd0, stop0, err}, 8'b10);
        clr = 1'b0;
`else
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            seen = seen | stop0 | err;
        end
        check("no_wdt_hold", {7'd0, seen}, 8'd0);
        req = 2'b00;
        tick();
        check("no_wdt_drop", {6'd0, stop0, err}, 8'b10);
`endif
        tick();

        req = 2'b01;
        wait_fall(0, "pre_async", n);
        #2 mrst_n = 1'b0;
        #1 check("async_reset", {5'd0, stop0, stop1, ack[0]}, 8'b110);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
